vending_machine_gen: RTL and testbench
======================================

# vending_machine_gen

Parametrised coin-accepting vending controller that generalises the fixed three-state quarter machine. It accepts nickels, dimes and quarters, accumulates credit up to a configurable price, and pulses `dispense` when the price is reached. It reports the exact change amount in cents and rejects illegal coin inputs. It sits between the coin-validator front end and the dispense/change actuators.

## Interface
- `PRICE`, 50: product price in cents; must be a nonzero multiple of 5.
- `CREDIT_W`, 8: width of the credit and change datapath; must satisfy 2^CREDIT_W > PRICE+20.
- `clk` input 1: clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `N_in` input 1: nickel (5c) accepted, single-cycle pulse.
- `D_in` input 1: dime (10c) accepted, single-cycle pulse.
- `Q_in` input 1: quarter (25c) accepted, single-cycle pulse.
- `cancel` input 1: refund request, single-cycle pulse (functional only with `VM_CANCEL_EN`).
- `dispense` output 1: vend pulse, one cycle.
- `change_valid` output 1: `change_amt` is valid this cycle, one-cycle pulse.
- `change_amt` output CREDIT_W: change in cents; 0 when `change_valid`=0.
- `coin_reject` output 1: previous-cycle coin was rejected (return to user), one-cycle pulse.
- `credit` output CREDIT_W: current accumulated credit in cents.

## Operation
- States:
  - IDLE: credit=0.
  - COLLECT: 0<credit<PRICE.
  - VEND: one cycle.
  - REFUND: one cycle, only present with `VM_CANCEL_EN`.
- Coin value `v` each cycle: N=5, D=10, Q=25, none=0. More than one of N/D/Q high at once is illegal: `v`=0, and `coin_reject`=1 next cycle.
- IDLE/COLLECT with legal coin: `sum = credit + v`, computed at CREDIT_W+1 bits.
  - If `sum` >= PRICE: go to VEND. `dispense`<=1, `change_amt`<=sum-PRICE, `change_valid`<=(sum≠PRICE), credit<=0.
  - Otherwise: credit<=sum, and the state goes to COLLECT.
- VEND: return to IDLE unconditionally. Any coin presented in the VEND cycle is rejected (`coin_reject`=1 next cycle), never credited.
- `cancel` in COLLECT (with `VM_CANCEL_EN`): go to REFUND. `change_valid`<=1, `change_amt`<=credit, credit<=0, `dispense`=0.
  - A coin in the same cycle as `cancel` is rejected.
  - REFUND returns to IDLE; coins during REFUND are rejected.
- `cancel` in IDLE, VEND or REFUND: ignored.
- Max credit before vend is PRICE-5, so max change is 20c. No overflow is possible when the parameter rule holds.
- Unreachable state encodings decode to IDLE.

## Timing
- All outputs are registered. The response appears on the cycle after the triggering input edge (latency 1).
- `dispense`, `change_valid`, `coin_reject`: exactly one cycle high per event. `dispense` and `change_valid` are coincident on a vend with change.
- `credit` updates one cycle after the coin.
- Reset (any time, including mid-collection): the state goes to IDLE and credit is lost. All outputs are 0 (`dispense`, `change_valid`, `change_amt`, `coin_reject`, `credit`) while `rstn`=0 and on the first cycle after release.
- Back-to-back legal coins on consecutive cycles are all accepted while in IDLE/COLLECT.

## Configuration
- `VM_CANCEL_EN` defined: the REFUND state and cancel logic are compiled in, and behave as in Operation.
- `VM_CANCEL_EN` undefined: the `cancel` port remains but is ignored. REFUND does not exist, and credit persists until vend or reset.

## Structure
- Package `vm_pkg` holds:
  - the state enum (IDLE, COLLECT, VEND, REFUND);
  - coin value constants NICKEL_C=5, DIME_C=10, QUARTER_C=25.
- Sub-module `vm_coin_decoder` (combinational): takes N/D/Q and outputs value `v` and an `illegal` flag. The top module holds the FSM, credit register and output registers.

## Test plan
- PRICE=50. Q, idle, Q: `credit`=25 after the first coin. One cycle after the second Q: `dispense`=1, `change_valid`=0, `credit`=0.
- N, Q, Q: `credit`=5 then 30. Then `dispense`=1, `change_valid`=1, `change_amt`=5, and the state returns to IDLE.
- N and Q high in the same cycle from IDLE: `coin_reject`=1 next cycle, `credit` stays 0, no dispense.
- With `VM_CANCEL_EN`: D, D, cancel: `credit`=20. Then `change_valid`=1, `change_amt`=20, `dispense`=0, `credit`=0. Without the macro, the same stimulus leaves `credit`=20.
- Q, Q, then Q in the VEND cycle: the vend occurs, and the third Q gives `coin_reject`=1 with `credit` remaining 0.
- Q, then `rstn` low mid-collection: all outputs 0. After release, Q, Q gives exactly one dispense with no residual credit.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the parametrised vending controller.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } vm_state_t;

    localparam int COIN_W = 5;

    localparam logic [COIN_W-1:0] NICKEL_C  = 5'd5;
    localparam logic [COIN_W-1:0] DIME_C    = 5'd10;
    localparam logic [COIN_W-1:0] QUARTER_C = 5'd25;

endpackage

// File: rtl/vm_coin_decoder.sv
// Combinational coin decoder: one-hot N/D/Q to a cent value, with a flag
// for simultaneous coins (which are given value 0).
module vm_coin_decoder
    import vm_pkg::*;
(
    input  logic              N_in,
    input  logic              D_in,
    input  logic              Q_in,
    output logic [COIN_W-1:0] value,
    output logic              illegal
);

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case ({N_in, D_in, Q_in})
            3'b000:  value = '0;
            3'b100:  value = NICKEL_C;
            3'b010:  value = DIME_C;
            3'b001:  value = QUARTER_C;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vending_machine_gen.sv
// Coin-accepting vending controller with registered outputs and latency 1.
// Optional refund path is compiled in when VM_CANCEL_EN is defined.
module vending_machine_gen
    import vm_pkg::*;
#(
    parameter int PRICE    = 50,
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                N_in,
    input  logic                D_in,
    input  logic                Q_in,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);

    vm_state_t           state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                dispense_reg, dispense_next;
    logic                change_valid_reg, change_valid_next;
    logic [CREDIT_W-1:0] change_amt_reg, change_amt_next;
    logic                coin_reject_reg, coin_reject_next;

    logic [COIN_W-1:0]   coin_value;
    logic                coin_illegal;
    logic                any_coin;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   excess;

    vm_coin_decoder u_decoder (
        .N_in    (N_in),
        .D_in    (D_in),
        .Q_in    (Q_in),
        .value   (coin_value),
        .illegal (coin_illegal)
    );

    assign any_coin = N_in | D_in | Q_in;
    // One extra bit so the pre-vend sum can never wrap.
    assign sum      = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_value);
    assign excess   = sum - PRICE_X;

`ifndef VM_CANCEL_EN
    logic unused_cancel;
    assign unused_cancel = cancel;
`endif

    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        dispense_next     = 1'b0;
        change_valid_next = 1'b0;
        change_amt_next   = '0;
        coin_reject_next  = 1'b0;
        case (state_reg)
            IDLE, COLLECT: begin
`ifdef VM_CANCEL_EN
                if (state_reg == COLLECT && cancel) begin
                    state_next        = REFUND;
                    change_valid_next = 1'b1;
                    change_amt_next   = credit_reg;
                    credit_next       = '0;
                    coin_reject_next  = any_coin;
                end else
`endif
                if (coin_illegal) begin
                    coin_reject_next = 1'b1;
                end else if (sum >= PRICE_X) begin
                    state_next        = VEND;
                    dispense_next     = 1'b1;
                    change_amt_next   = excess[CREDIT_W-1:0];
                    change_valid_next = (sum != PRICE_X);
                    credit_next       = '0;
                end else begin
                    credit_next = sum[CREDIT_W-1:0];
                    state_next  = (sum == '0) ? IDLE : COLLECT;
                end
            end
            VEND: begin
                state_next       = IDLE;
                coin_reject_next = any_coin;
            end
`ifdef VM_CANCEL_EN
            REFUND: begin
                state_next       = IDLE;
                coin_reject_next = any_coin;
            end
`endif
            default: begin
                state_next  = IDLE;
                credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            dispense_reg     <= 1'b0;
            change_valid_reg <= 1'b0;
            change_amt_reg   <= '0;
            coin_reject_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            dispense_reg     <= dispense_next;
            change_valid_reg <= change_valid_next;
            change_amt_reg   <= change_amt_next;
            coin_reject_reg  <= coin_reject_next;
        end
    end

    assign dispense     = dispense_reg;
    assign change_valid = change_valid_reg;
    assign change_amt   = change_amt_reg;
    assign coin_reject  = coin_reject_reg;
    assign credit       = credit_reg;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed self-checking bench for vending_machine_gen at PRICE=50, CREDIT_W=8.
// Observed word is {dispense, change_valid, change_amt, coin_reject, credit}.
module tb_vending_machine_gen;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       N_in = 1'b0;
    logic       D_in = 1'b0;
    logic       Q_in = 1'b0;
    logic       cancel = 1'b0;
    logic       dispense;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic [7:0] credit;

    logic [18:0] obs;
    int assertions = 0;
    int failures   = 0;

    assign obs = {dispense, change_valid, change_amt, coin_reject, credit};

    vending_machine_gen #(.PRICE(50), .CREDIT_W(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .N_in         (N_in),
        .D_in         (D_in),
        .Q_in         (Q_in),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .credit       (credit)
    );

    always #5 clk = ~clk;

    // Present inputs for one clock edge, then sample #1 after that edge.
    task automatic apply(input logic n, input logic d, input logic q, input logic c);
        N_in = n; D_in = d; Q_in = q; cancel = c;
        @(posedge clk);
        #1;
        N_in = 1'b0; D_in = 1'b0; Q_in = 1'b0; cancel = 1'b0;
        $display("tx N=%0b D=%0b Q=%0b cancel=%0b -> disp=%0b cv=%0b amt=%0d rej=%0b credit=%0d",
                 n, d, q, c, dispense, change_valid, change_amt, coin_reject, credit);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL reset_hold: got %h required %h", obs, 19'h0);
        end
        rstn = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL reset_release: got %h required %h", obs, 19'h0);
        end
    endtask

    task automatic test_exact_vend;
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b0, 8'd25}) begin
            failures++;
            $display("FAIL exact_q1: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b0, 8'd25});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b0, 8'd25}) begin
            failures++;
            $display("FAIL exact_idle: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b0, 8'd25});
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL exact_vend: got %h required %h", obs, {1'b1, 1'b0, 8'd0, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL exact_after: got %h required %h", obs, 19'h0);
        end
    endtask

    task automatic test_change;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (credit !== 8'd5) begin
            failures++;
            $display("FAIL change_n: credit got %0d required 5", credit);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (credit !== 8'd30) begin
            failures++;
            $display("FAIL change_nq: credit got %0d required 30", credit);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b1, 1'b1, 8'd5, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL change_vend: got %h required %h", obs, {1'b1, 1'b1, 8'd5, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL change_after: got %h required %h", obs, 19'h0);
        end
    endtask

    task automatic test_illegal;
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL illegal_nq: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b1, 8'd0});
        end
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL illegal_dq: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b1, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL illegal_after: got %h required %h", obs, 19'h0);
        end
    endtask

    task automatic test_cancel;
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL cancel_idle: got %h required %h", obs, 19'h0);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        assertions++;
        if (credit !== 8'd20) begin
            failures++;
            $display("FAIL cancel_dd: credit got %0d required 20", credit);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef VM_CANCEL_EN
        assertions++;
        if (obs !== {1'b0, 1'b1, 8'd20, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL cancel_refund: got %h required %h", obs, {1'b0, 1'b1, 8'd20, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL cancel_coin_in_refund: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b1, 8'd0});
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b1);
        assertions++;
        if (obs !== {1'b0, 1'b1, 8'd10, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL cancel_with_coin: got %h required %h", obs, {1'b0, 1'b1, 8'd10, 1'b1, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
`else
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b0, 8'd20}) begin
            failures++;
            $display("FAIL cancel_ignored: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b0, 8'd20});
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL cancel_persist_vend: got %h required %h", obs, {1'b1, 1'b0, 8'd0, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
`endif
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL cancel_after: got %h required %h", obs, 19'h0);
        end
    endtask

    task automatic test_vend_coin;
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL vendcoin_vend: got %h required %h", obs, {1'b1, 1'b0, 8'd0, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL vendcoin_reject: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b1, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL vendcoin_after: got %h required %h", obs, 19'h0);
        end
    endtask

    task automatic test_back_to_back;
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        assertions++;
        if (credit !== 8'd25) begin
            failures++;
            $display("FAIL b2b_ndd: credit got %0d required 25", credit);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL b2b_vend1: got %h required %h", obs, {1'b1, 1'b0, 8'd0, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        // Largest reachable credit (45) plus a quarter gives the 20c maximum change.
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, 1'b0);
        assertions++;
        if (credit !== 8'd45) begin
            failures++;
            $display("FAIL b2b_45: credit got %0d required 45", credit);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b1, 1'b1, 8'd20, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL b2b_maxchange: got %h required %h", obs, {1'b1, 1'b1, 8'd20, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL b2b_vend_reject: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b1, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (credit !== 8'd25) begin
            failures++;
            $display("FAIL rstmid_q: credit got %0d required 25", credit);
        end
        rstn = 1'b0;
        #1;
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL rstmid_async: got %h required %h", obs, 19'h0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL rstmid_release: got %h required %h", obs, 19'h0);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b0, 1'b0, 8'd0, 1'b0, 8'd25}) begin
            failures++;
            $display("FAIL rstmid_q1: got %h required %h", obs, {1'b0, 1'b0, 8'd0, 1'b0, 8'd25});
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        assertions++;
        if (obs !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL rstmid_vend: got %h required %h", obs, {1'b1, 1'b0, 8'd0, 1'b0, 8'd0});
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obs !== 19'h0) begin
            failures++;
            $display("FAIL rstmid_after: got %h required %h", obs, 19'h0);
        end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_illegal();
        test_cancel();
        test_vend_coin();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
